// File: rtl/kernel_led_sequencer.sv
// kernel_led_sequencer: Avalon-MM slave that steps a pattern on the board LED bank.
// Software programs a pattern, a mode and a step period. The block then steps the
// pattern on its own, with one step every PERIOD+1 clocks.
//
// Optional feature macro: LED_SEQ_PWM_EN adds a 4-bit duty field in CTRL[7:4]
// (reset 15) that PWM-gates the LED outputs.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select: 0 CTRL, 1 PATTERN, 2 PERIOD, 3 STATUS
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational from address, unused bits zero
//   out_port    registered LED drive
module kernel_led_sequencer #(
    parameter int unsigned PRESC_W = 24,
    parameter int unsigned LED_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic [LED_W-1:0]   out_port
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE_L = 2'd2,
        MODE_CHASE_R = 2'd3
    } mode_e;

    localparam int unsigned STAT_W = 8;

    mode_e                mode_q,    mode_d;
    logic                 en_q,      en_d;
    logic [LED_W-1:0]     pattern_q, pattern_d;
    logic [PRESC_W-1:0]   period_q,  period_d;
    logic [STAT_W-1:0]    status_q,  status_d;
    logic [PRESC_W-1:0]   cnt_q,     cnt_d;
    logic [LED_W-1:0]     wr_q,      wr_d;
    logic                 ph_q,      ph_d;
    logic [LED_W-1:0]     out_q,     out_d;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]           duty_q,    duty_d;
    logic [3:0]           pwm_cnt_q, pwm_cnt_d;
    logic                 pwm_gate;
`endif

    logic                 wr_en;
    logic                 we_ctrl, we_pat, we_per, we_stat;
    logic                 step;
    logic [LED_W-1:0]     seq_val;
    logic [7:0]           ctrl_rd;
    logic                 unused_wdata;

    // Write strobes per register
    assign wr_en   = chipselect & ~write_n;
    assign we_ctrl = wr_en && (address == 2'd0);
    assign we_pat  = wr_en && (address == 2'd1);
    assign we_per  = wr_en && (address == 2'd2);
    assign we_stat = wr_en && (address == 2'd3);

    // Not every writedata bit maps to a register field
    assign unused_wdata = ^writedata;

    // Step pulse. A CTRL or PERIOD write restarts the prescaler and suppresses the step.
    assign step = en_q && (cnt_q == period_q) && !(we_ctrl || we_per);

    // Next-state logic for the registers, prescaler, working pattern and status
    always_comb begin
        mode_d    = mode_q;
        en_d      = en_q;
        pattern_d = pattern_q;
        period_d  = period_q;
        status_d  = status_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        ph_d      = ph_q;
`ifdef LED_SEQ_PWM_EN
        duty_d    = duty_q;
        pwm_cnt_d = pwm_cnt_q + 4'd1;
`endif

        if (we_ctrl) begin
            mode_d = mode_e'(writedata[1:0]);
            en_d   = writedata[2];
`ifdef LED_SEQ_PWM_EN
            duty_d = writedata[7:4];
`endif
        end
        if (we_pat) pattern_d = writedata[LED_W-1:0];
        if (we_per) period_d  = writedata[PRESC_W-1:0];

        // Prescaler
        if (!en_q || we_ctrl || we_per) begin
            cnt_d = '0;
        end else if (cnt_q == period_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PRESC_W'(1);
        end

        // Working register. A reload takes priority over a coincident step.
        if (we_ctrl || we_pat) begin
            wr_d = pattern_d;
            ph_d = 1'b1;
        end else if (step) begin
            unique case (mode_q)
                MODE_BLINK:   ph_d = ~ph_q;
                MODE_CHASE_L: wr_d = {wr_q[LED_W-2:0], wr_q[LED_W-1]};
                MODE_CHASE_R: wr_d = {wr_q[0], wr_q[LED_W-1:1]};
                default:      wr_d = wr_q;
            endcase
        end

        // Step counter. A clear wins over a coincident step.
        if (we_stat) begin
            status_d = '0;
        end else if (step) begin
            status_d = status_q + STAT_W'(1);
        end
    end

    // Sequencer value before enable and PWM gating
    always_comb begin
        seq_val = '0;
        unique case (mode_q)
            MODE_STATIC: seq_val = pattern_q;
            MODE_BLINK:  seq_val = ph_q ? pattern_q : '0;
            default:     seq_val = wr_q;
        endcase
    end

`ifdef LED_SEQ_PWM_EN
    assign pwm_gate = (duty_q == 4'hF) || (pwm_cnt_q < duty_q);
    assign out_d    = en_q ? (seq_val & {LED_W{pwm_gate}}) : '0;
    assign ctrl_rd  = {duty_q, 1'b0, en_q, mode_q};
`else
    assign out_d    = en_q ? seq_val : '0;
    assign ctrl_rd  = {5'b0, en_q, mode_q};
`endif

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_STATIC;
            en_q      <= 1'b0;
            pattern_q <= '0;
            period_q  <= '0;
            status_q  <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            ph_q      <= 1'b0;
            out_q     <= '0;
`ifdef LED_SEQ_PWM_EN
            duty_q    <= 4'hF;
            pwm_cnt_q <= 4'd0;
`endif
        end else begin
            mode_q    <= mode_d;
            en_q      <= en_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            status_q  <= status_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            ph_q      <= ph_d;
            out_q     <= out_d;
`ifdef LED_SEQ_PWM_EN
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
`endif
        end
    end

    // Read mux, no side effects
    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0: readdata = 32'(ctrl_rd);
            2'd1: readdata = 32'(pattern_q);
            2'd2: readdata = 32'(period_q);
            default: readdata = 32'(status_q);
        endcase
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_kernel_led_sequencer.sv
// Directed self-checking bench for kernel_led_sequencer.
module tb_kernel_led_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_checks = 0;
    int n_fail   = 0;

    // Duty nibble OR'd into every CTRL write; ignored when PWM is compiled out
    localparam logic [31:0] DHI = 32'h0000_00F0;
`ifdef LED_SEQ_PWM_EN
    localparam logic [31:0] CTRL_RST = 32'h0000_00F0;
`else
    localparam logic [31:0] CTRL_RST = 32'h0000_0000;
`endif

    kernel_led_sequencer #(.PRESC_W(24), .LED_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    // Drives one write across a single rising edge, returning at the next falling edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    function automatic logic [31:0] ctrl_exp(input logic [31:0] w);
`ifdef LED_SEQ_PWM_EN
        return {24'b0, w[7:4], 1'b0, w[2:0]};
`else
        return {29'b0, w[2:0]};
`endif
    endfunction

    initial begin
        int ones [4];
        logic [3:0] acc;

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #23 reset_n = 1'b1;

        // 1: reset values
        @(negedge clk);
        rd_check(2'd0, CTRL_RST, "rst_ctrl");
        rd_check(2'd1, 32'h0, "rst_pattern");
        rd_check(2'd2, 32'h0, "rst_period");
        rd_check(2'd3, 32'h0, "rst_status");
        check("rst_out", 32'(out_port), 32'h0);

        // Writes without chipselect or without the strobe are ignored
        @(negedge clk);
        address = 2'd1; writedata = 32'hA; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        rd_check(2'd1, 32'h0, "ignored_write");

        // 2: STATIC, step every cycle
        wr(2'd1, 32'h5);
        wr(2'd2, 32'h0);
        wr(2'd0, DHI | 32'h4);
        rd_check(2'd0, ctrl_exp(DHI | 32'h4), "ctrl_readback");
        rd_check(2'd1, 32'h5, "pattern_readback");
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("static_out_%0d", i), 32'(out_port), 32'h5);
            rd_check(2'd3, 32'(i), $sformatf("static_status_%0d", i));
        end

        // 3: CHASE_L, step every 4 clocks
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h3);
        wr(2'd0, DHI | 32'h6);
        rd_check(2'd2, 32'h3, "period_readback");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("chase_l_%0d", i), 32'(out_port), 32'(4'b0001 << ((i / 4) % 4)));
        end

        // CHASE_R from 0x1 rotates to 0x8
        wr(2'd0, DHI | 32'h7);
        repeat (5) @(negedge clk);
        check("chase_r", 32'(out_port), 32'h8);

        // 4: BLINK, period 1
        wr(2'd1, 32'h9);
        wr(2'd2, 32'h1);
        wr(2'd0, DHI | 32'h5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", i), 32'(out_port), (((i / 2) % 2) == 0) ? 32'h9 : 32'h0);
        end
        wr(2'd0, DHI | 32'h1);
        @(negedge clk);
        check("disabled_out_a", 32'(out_port), 32'h0);
        repeat (3) @(negedge clk);
        check("disabled_out_b", 32'(out_port), 32'h0);

        // 5: STATUS wrap and clear beating a coincident step
        wr(2'd2, 32'h0);
        wr(2'd0, DHI | 32'h4);
        wr(2'd3, 32'h0);
        rd_check(2'd3, 32'h0, "status_cleared");
        repeat (255) @(negedge clk);
        rd_check(2'd3, 32'd255, "status_255");
        wr(2'd3, 32'h0);
        rd_check(2'd3, 32'h0, "clear_beats_step");
        @(negedge clk);
        rd_check(2'd3, 32'h1, "status_after_clear");
        repeat (255) @(negedge clk);
        rd_check(2'd3, 32'h0, "status_wrap");

        // 6: PWM gating, or CTRL[7:4] ignored when compiled out
        wr(2'd1, 32'hF);
        wr(2'd0, 32'h44);
        rd_check(2'd0, ctrl_exp(32'h44), "ctrl_duty_readback");
        @(negedge clk);
        for (int b = 0; b < 4; b++) ones[b] = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) ones[b] += int'(out_port[b]);
        end
        for (int b = 0; b < 4; b++) begin
`ifdef LED_SEQ_PWM_EN
            check($sformatf("pwm_on_count_%0d", b), 32'(ones[b]), 32'd4);
`else
            check($sformatf("pwm_on_count_%0d", b), 32'(ones[b]), 32'd16);
`endif
        end
        wr(2'd0, 32'h04);
        @(negedge clk);
        acc = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            acc = acc | out_port;
        end
`ifdef LED_SEQ_PWM_EN
        check("duty0_dark", 32'(acc), 32'h0);
`else
        check("duty0_dark", 32'(acc), 32'hF);
`endif

        // Reset mid-run clears everything immediately
        wr(2'd0, DHI | 32'h4);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out", 32'(out_port), 32'h0);
        rd_check(2'd0, CTRL_RST, "midrst_ctrl");
        rd_check(2'd1, 32'h0, "midrst_pattern");
        rd_check(2'd3, 32'h0, "midrst_status");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("after_rst_out", 32'(out_port), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
